// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with start/stop validation and one-cycle strobes.
// Optional feature macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx #(
  parameter int DATA_BITS = 16,
  parameter int STOP_BITS = 1,
  parameter     FIRST_BIT = "msb",
  parameter int BAUDRATE  = 115200,
  parameter int CLK_FREQ  = 75_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
  localparam bit LSB_FIRST    = (FIRST_BIT == "lsb");

  // The voting build decides one cycle later; every later sample inherits that offset.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = HALF_BIT;
`else
  localparam int START_LAST = HALF_BIT - 1;
`endif

  localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LAST);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, err_n;
  logic                 sync1, rx_s;
  logic                 sample;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // hist[0] is the mid-point sample and hist[1] the one before it when a decision is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      stop_cnt  <= stop_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    stop_n  = stop_cnt;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == START_END) begin
          cnt_n = '0;
          if (!sample) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (LSB_FIRST) shift_n = (shift >> 1) | (DATA_BITS'(sample) << (DATA_BITS - 1));
          else           shift_n = (shift << 1) | DATA_BITS'(sample);
          if (idx == LAST_IDX) begin
            state_n = STOP;
            stop_n  = 1'b0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (!sample) begin
            err_n   = 1'b1;
            state_n = BREAK;
          end else if (stop_cnt == LAST_STOP) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // A held-low line stays here so it reports one error rather than a stream of frames.
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, scoreboarded bench for uart_rx at 8 clocks per bit.
// Two receivers share one line: dut_m decodes MSB-first, dut_l decodes LSB-first.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 144;
  localparam logic [15:0] SPIKE_EXP = 16'hA5C3;
`else
  localparam int LAT = 143;
  localparam logic [15:0] SPIKE_EXP = 16'h5A3C;
`endif

  typedef struct {
    logic [15:0] word;
    bit          lsb_first;
    bit          stop_val;
    bit          spike;
    bit          chain;
    logic [15:0] exp_m;
    logic [15:0] exp_l;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        valid_m, err_m, busy_m, valid_l, err_l, busy_l;
  logic [15:0] data_m, data_l;

  uart_rx #(.DATA_BITS(16), .STOP_BITS(1), .FIRST_BIT("msb"),
            .BAUDRATE(115200), .CLK_FREQ(921600)) dut_m (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_valid(valid_m),
    .rx_data(data_m), .frame_err(err_m), .busy(busy_m));

  uart_rx #(.DATA_BITS(16), .STOP_BITS(1), .FIRST_BIT("lsb"),
            .BAUDRATE(115200), .CLK_FREQ(921600)) dut_l (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_valid(valid_l),
    .rx_data(data_l), .frame_err(err_l), .busy(busy_l));

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [15:0] got_m[$], got_l[$], exp_m[$], exp_l[$];
  int          got_cyc[$], exp_cyc[$];
  int          err_cnt_m = 0, err_cnt_l = 0, both_cnt = 0;
  int          n_cmp = 0, n_fail = 0;
  int          gm = 0, em = 0, gl = 0, el = 0, eb_m = 0, eb_l = 0;
  vec_t        vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture side of the scoreboard: everything the receivers emit, in order.
  always @(negedge clk) begin
    if (valid_m) begin
      got_m.push_back(data_m);
      got_cyc.push_back(cyc);
    end
    if (valid_l) got_l.push_back(data_l);
    if (err_m) err_cnt_m++;
    if (err_l) err_cnt_l++;
    if ((valid_m && err_m) || (valid_l && err_l)) both_cnt++;
  end

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input int act, input int req);
    n_cmp++;
    if (act < req - 1 || act > req + 1) begin
      n_fail++;
      $display("[TB] FAIL %s: got cycle %0d, expected %0d +/-1", name, act, req);
    end
  endtask

  // Line driver; always entered and left on a falling clock edge.
  task automatic drive_bit(input logic b, input bit spike);
    for (int c = 0; c < CPB; c++) begin
      rx = (spike && c == HALF) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] word, input bit lsb_first, input bit stop_val,
                                input bit spike, input bit expect_word,
                                input logic [15:0] xm, input logic [15:0] xl);
    if (expect_word) begin
      exp_m.push_back(xm);
      exp_l.push_back(xl);
      exp_cyc.push_back(cyc + LAT);
    end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive_bit(lsb_first ? word[i] : word[15-i], spike);
    drive_bit(stop_val, 1'b0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input int exp_err);
    int ngm, nem, ngl, nel;
    ngm = got_m.size() - gm;
    nem = exp_m.size() - em;
    ngl = got_l.size() - gl;
    nel = exp_l.size() - el;
    check({name, " words_m"}, ngm, nem);
    check({name, " words_l"}, ngl, nel);
    for (int i = 0; i < ngm && i < nem; i++) begin
      check({name, " data_m"}, got_m[gm+i], exp_m[em+i]);
      check_near({name, " latency"}, got_cyc[gm+i], exp_cyc[em+i]);
    end
    for (int i = 0; i < ngl && i < nel; i++) check({name, " data_l"}, got_l[gl+i], exp_l[el+i]);
    check({name, " frame_err_m"}, err_cnt_m - eb_m, exp_err);
    check({name, " frame_err_l"}, err_cnt_l - eb_l, exp_err);
    gm = got_m.size(); em = exp_m.size();
    gl = got_l.size(); el = exp_l.size();
    eb_m = err_cnt_m;  eb_l = err_cnt_l;
  endtask

  task automatic check_reset_state(input string name);
    check({name, " data_m"}, data_m, 0);
    check({name, " data_l"}, data_l, 0);
    check({name, " strobes"}, {valid_m, err_m, valid_l, err_l}, 0);
    check({name, " busy"}, {busy_m, busy_l}, 0);
  endtask

  initial begin
    int bm, bl;
    logic [15:0] prev_m, prev_l, w;

    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5C3, rev16(16'hA5C3)};
    vecs[1] = '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, rev16(16'h1234), 16'h1234};
    vecs[2] = '{16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h0001};
    vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b0, SPIKE_EXP, rev16(SPIKE_EXP)};
    vecs[5] = '{16'h3C96, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3C96, rev16(16'h3C96)};

    repeat (4) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(4);

    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].word, vecs[v].lsb_first, vecs[v].stop_val, vecs[v].spike,
                     1'b1, vecs[v].exp_m, vecs[v].exp_l);
      if (!vecs[v].chain) begin
        idle(16);
        check_output($sformatf("vec%0d", v), 0);
      end
    end

    // Bad stop bit followed by a long break: one error, old word kept, busy held.
    prev_m = exp_m[exp_m.size()-1];
    prev_l = exp_l[exp_l.size()-1];
    apply_stimulus(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (40 * CPB) @(negedge clk);
    check("break busy", {busy_m, busy_l}, 2'b11);
    check("break keep_m", data_m, prev_m);
    check("break keep_l", data_l, prev_l);
    check_output("break", 1);
    idle(20);
    check("break release busy", {busy_m, busy_l}, 2'b00);
    apply_stimulus(16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, rev16(16'h00FF));
    idle(16);
    check_output("after_break", 0);

    // Start glitch shorter than half a bit.
    bm = 0; bl = 0;
    for (int i = 0; i < 30; i++) begin
      rx = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy_m) bm++;
      if (busy_l) bl++;
    end
    check("glitch busy_m in range", (bm >= 1 && bm <= HALF + 2), 1);
    check("glitch busy_l in range", (bl >= 1 && bl <= HALF + 2), 1);
    check("glitch idle", {busy_m, busy_l}, 2'b00);
    check_output("glitch", 0);

    // Reset pulse in the middle of data bit 7 aborts the frame.
    w = 16'hBEEF;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(w[15-i], 1'b0);
    for (int c = 0; c < HALF; c++) begin
      rx = w[8];
      @(negedge clk);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midframe_reset");
    idle(40);
    check_output("reset_abort", 0);
    apply_stimulus(16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, rev16(16'hBEEF));
    idle(16);
    check_output("after_reset", 0);

    check("valid_with_err", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
